// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - state_e       : sequencer states (RUN, MD_WAIT, HALT)
//   - MD_LAT_DEF    : default mul/div occupancy of EX, in cycles
//   - MEM_TO_DEF    : default memory-wait timeout, in cycles
//   - STALL_W       : width of the saturating stall-cycle counter
//   - sat_inc_stall : saturating increment for the stall counter
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_e;

    localparam int MD_LAT_DEF = 4;
    localparam int MEM_TO_DEF = 255;
    localparam int STALL_W    = 16;

    function automatic logic [STALL_W-1:0] sat_inc_stall(input logic [STALL_W-1:0] v);
        if (v == {STALL_W{1'b1}}) begin
            return v;
        end
        return v + {{(STALL_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ctrl_down_counter.sv
// -----------------------------------------------------------------------------
// ctrl_down_counter
// Loadable down-counter with a zero flag. Load has priority over decrement;
// decrementing stops at zero.
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous active-low reset (count clears to 0)
//   load_i     in  load load_val_i this cycle
//   load_val_i in  W-bit load value
//   dec_i      in  decrement this cycle (ignored at zero)
//   zero_o     out count is zero
// -----------------------------------------------------------------------------
module ctrl_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Combines load-use
// stalls, branch/jump redirects, the mul/div occupancy, data-memory waits and
// halt into write enables and bubble strobes for the PC and every pipeline
// register. Outputs are combinational from state and inputs.
// Ports:
//   clk, rst_n                  clock / asynchronous active-low reset
//   loaduse_stall               load-use hazard from the hazard unit
//   branch_taken                taken branch resolved in EX
//   jump                        jump decoded in ID
//   md_start                    mul/div op present in EX
//   dmem_req, dmem_ready        MEM-stage access handshake
//   halt                        halt instruction retiring in WB
//   pc_we .. memwb_we           register write enables
//   ifid_flush .. memwb_flush   bubble-insert strobes
//   md_busy                     state is MD_WAIT
//   halted                      state is HALT
//   mem_err                     sticky memory-timeout flag
//   stall_cnt                   saturating count of pc_we=0 cycles outside HALT
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT      = MD_LAT_DEF,
    parameter int MEM_TIMEOUT = MEM_TO_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               loaduse_stall,
    input  logic               branch_taken,
    input  logic               jump,
    input  logic               md_start,
    input  logic               dmem_req,
    input  logic               dmem_ready,
    input  logic               halt,
    output logic               pc_we,
    output logic               ifid_we,
    output logic               idex_we,
    output logic               exmem_we,
    output logic               memwb_we,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               exmem_flush,
    output logic               memwb_flush,
    output logic               md_busy,
    output logic               halted,
    output logic               mem_err,
    output logic [STALL_W-1:0] stall_cnt
);

    // md_cnt only ever holds MD_LAT-2, so $clog2(MD_LAT) bits suffice.
    localparam int MD_W = $clog2(MD_LAT);

    state_e             state_q, state_d;
    logic [15:0]        to_cnt_q, to_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    logic               md_load, md_dec, md_zero;
    logic [16:0]        to_inc;
    logic               mem_wait;

    // Unreset-gated enables/flushes; gated by rst_n at the ports.
    logic pc_we_c, ifid_we_c, idex_we_c, exmem_we_c, memwb_we_c;
    logic ifid_fl_c, idex_fl_c, exmem_fl_c, memwb_fl_c;

    ctrl_down_counter #(.W(MD_W)) u_md_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (md_load),
        .load_val_i (MD_W'(MD_LAT - 2)),
        .dec_i      (md_dec),
        .zero_o     (md_zero)
    );

    assign mem_wait = dmem_req && !dmem_ready && (state_q != ST_HALT);
    assign to_inc   = {1'b0, to_cnt_q} + 17'd1;

    always_comb begin
        pc_we_c    = 1'b1;
        ifid_we_c  = 1'b1;
        idex_we_c  = 1'b1;
        exmem_we_c = 1'b1;
        memwb_we_c = 1'b1;
        ifid_fl_c  = 1'b0;
        idex_fl_c  = 1'b0;
        exmem_fl_c = 1'b0;
        memwb_fl_c = 1'b0;
        md_load    = 1'b0;
        md_dec     = 1'b0;
        to_cnt_d   = '0;
        state_d    = state_q;
        mem_err_d  = mem_err_q;

        if (state_q == ST_HALT) begin
            pc_we_c    = 1'b0;
            ifid_we_c  = 1'b0;
            idex_we_c  = 1'b0;
            exmem_we_c = 1'b0;
            memwb_we_c = 1'b0;
        end else begin
            if (mem_wait) begin
                // Hold everything up to MEM; WB receives a bubble.
                pc_we_c    = 1'b0;
                ifid_we_c  = 1'b0;
                idex_we_c  = 1'b0;
                exmem_we_c = 1'b0;
                memwb_fl_c = 1'b1;
                to_cnt_d   = to_inc[15:0];
                if (to_inc == 17'(MEM_TIMEOUT)) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end else if (state_q == ST_MD_WAIT) begin
                if (!md_zero) begin
                    pc_we_c    = 1'b0;
                    ifid_we_c  = 1'b0;
                    idex_we_c  = 1'b0;
                    exmem_fl_c = 1'b1;
                    md_dec     = 1'b1;
                end else begin
                    // Release cycle: defaults, md_start not re-sampled.
                    state_d = ST_RUN;
                end
            end else if (md_start && !branch_taken) begin
                pc_we_c    = 1'b0;
                ifid_we_c  = 1'b0;
                idex_we_c  = 1'b0;
                exmem_fl_c = 1'b1;
                md_load    = 1'b1;
                state_d    = ST_MD_WAIT;
            end else if (branch_taken) begin
                ifid_fl_c = 1'b1;
                idex_fl_c = 1'b1;
            end else if (loaduse_stall) begin
                pc_we_c   = 1'b0;
                ifid_we_c = 1'b0;
                idex_fl_c = 1'b1;
            end else if (jump) begin
                ifid_fl_c = 1'b1;
            end

            // The retiring halt completes normally; the pipeline stops after it.
            if (halt) begin
                state_d = ST_HALT;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_we_c && (state_q != ST_HALT)) begin
            stall_cnt_d = sat_inc_stall(stall_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            to_cnt_q    <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // All enables and strobes are forced low while reset is held.
    assign pc_we       = rst_n & pc_we_c;
    assign ifid_we     = rst_n & ifid_we_c;
    assign idex_we     = rst_n & idex_we_c;
    assign exmem_we    = rst_n & exmem_we_c;
    assign memwb_we    = rst_n & memwb_we_c;
    assign ifid_flush  = rst_n & ifid_fl_c;
    assign idex_flush  = rst_n & idex_fl_c;
    assign exmem_flush = rst_n & exmem_fl_c;
    assign memwb_flush = rst_n & memwb_fl_c;

    assign md_busy   = (state_q == ST_MD_WAIT);
    assign halted    = (state_q == ST_HALT);
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        loaduse_stall, branch_taken, jump, md_start;
    logic        dmem_req, dmem_ready, halt;
    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        md_busy, halted, mem_err;
    logic [15:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MD_LAT(4), .MEM_TIMEOUT(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .loaduse_stall (loaduse_stall),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .md_start      (md_start),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .halt          (halt),
        .pc_we         (pc_we),
        .ifid_we       (ifid_we),
        .idex_we       (idex_we),
        .exmem_we      (exmem_we),
        .memwb_we      (memwb_we),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .memwb_flush   (memwb_flush),
        .md_busy       (md_busy),
        .halted        (halted),
        .mem_err       (mem_err),
        .stall_cnt     (stall_cnt)
    );

    // {pc,ifid,idex,exmem,memwb}_we, {ifid,idex,exmem,memwb}_flush, md_busy, halted, mem_err
    logic [11:0] obs;
    assign obs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush,
                  md_busy, halted, mem_err};

    // in = {loaduse_stall, branch_taken, jump, md_start, dmem_req, dmem_ready, halt}
    typedef struct {
        logic [6:0]  in;
        logic [11:0] exp;
        logic [15:0] stall;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        {loaduse_stall, branch_taken, jump, md_start, dmem_req, dmem_ready, halt} = v;
    endtask

    // Drive just after a rising edge, sample at the following falling edge.
    task automatic cycle(input logic [6:0] v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{7'b0000000, 12'b11111_0000_000, 16'd0};
        tbl[1]  = '{7'b0000000, 12'b11111_0000_000, 16'd0};
        tbl[2]  = '{7'b1010000, 12'b00111_0100_000, 16'd0};  // loaduse + jump
        tbl[3]  = '{7'b0000000, 12'b11111_0000_000, 16'd1};
        tbl[4]  = '{7'b1100000, 12'b11111_1100_000, 16'd1};  // branch beats loaduse
        tbl[5]  = '{7'b0010000, 12'b11111_1000_000, 16'd1};  // jump alone
        tbl[6]  = '{7'b0101000, 12'b11111_1100_000, 16'd1};  // branch beats md_start
        tbl[7]  = '{7'b0001000, 12'b00011_0010_000, 16'd1};  // md start T
        tbl[8]  = '{7'b0001000, 12'b00011_0010_100, 16'd2};
        tbl[9]  = '{7'b1000000, 12'b00011_0010_100, 16'd3};
        tbl[10] = '{7'b0101000, 12'b11111_0000_100, 16'd4};  // release T+3
        tbl[11] = '{7'b0000000, 12'b11111_0000_000, 16'd4};
        tbl[12] = '{7'b0001110, 12'b00011_0010_000, 16'd4};  // md start, mem ready
        tbl[13] = '{7'b0000100, 12'b00001_0001_100, 16'd5};  // mem wait in MD_WAIT
        tbl[14] = '{7'b0000110, 12'b00011_0010_100, 16'd6};
        tbl[15] = '{7'b0000000, 12'b00011_0010_100, 16'd7};
        tbl[16] = '{7'b0000000, 12'b11111_0000_100, 16'd8};  // release moved by one
        tbl[17] = '{7'b0000100, 12'b00001_0001_000, 16'd8};
        tbl[18] = '{7'b0000100, 12'b00001_0001_000, 16'd9};
        tbl[19] = '{7'b0000110, 12'b11111_0000_000, 16'd10}; // ready: normal cycle
        tbl[20] = '{7'b0000100, 12'b00001_0001_000, 16'd10}; // timeout run starts
        tbl[21] = '{7'b0000100, 12'b00001_0001_000, 16'd11};
        tbl[22] = '{7'b0000100, 12'b00001_0001_000, 16'd12};
        tbl[23] = '{7'b0000000, 12'b00000_0000_011, 16'd13}; // HALT + mem_err
        tbl[24] = '{7'b1100100, 12'b00000_0000_011, 16'd13};
        tbl[25] = '{7'b0000000, 12'b00000_0000_011, 16'd13};

        rst_n = 1'b0;
        drive(7'b0);
        repeat (2) @(negedge clk);
        chk("reset_outputs", {20'd0, obs}, 32'd0);
        chk("reset_stall", {16'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            cycle(tbl[i].in);
            chk($sformatf("vec%0d_out", i), {20'd0, obs}, {20'd0, tbl[i].exp});
            chk($sformatf("vec%0d_stall", i), {16'd0, stall_cnt}, {16'd0, tbl[i].stall});
        end

        // Asynchronous reset in the middle of HALT clears before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", {20'd0, obs}, 32'd0);
        chk("async_rst_stall", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        chk("rst_held_out", {20'd0, obs}, 32'd0);
        rst_n = 1'b1;

        // halt during MD_WAIT: freeze continues that cycle, HALT on the next.
        cycle(7'b0001000);
        chk("hmd_start", {20'd0, obs}, {20'd0, 12'b00011_0010_000});
        cycle(7'b0000001);
        chk("hmd_halt_cyc", {20'd0, obs}, {20'd0, 12'b00011_0010_100});
        cycle(7'b0000000);
        chk("hmd_halted", {20'd0, obs}, {20'd0, 12'b00000_0000_010});
        chk("hmd_stall", {16'd0, stall_cnt}, 32'd2);
        cycle(7'b0010000);
        chk("hmd_still_halted", {20'd0, obs}, {20'd0, 12'b00000_0000_010});

        // halt in RUN: normal cycle, then HALT.
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(7'b0000001);
        chk("hrun_cyc", {20'd0, obs}, {20'd0, 12'b11111_0000_000});
        cycle(7'b0000000);
        chk("hrun_halted", {20'd0, obs}, {20'd0, 12'b00000_0000_010});
        chk("hrun_stall", {16'd0, stall_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
